// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit holding HI/LO.
// Pipelined multiply/MAC and iterative restoring divide.
module mdu_seq #(
  parameter int DATA_WIDTH         = 32,
  parameter int MUL_STAGES         = 2,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mdu_valid_i,
  input  logic [3:0]            mdu_op_i,
  input  logic [DATA_WIDTH-1:0] mdu_a_i,
  input  logic [DATA_WIDTH-1:0] mdu_b_i,
  input  logic                  mdu_flush_i,
  output logic [DATA_WIDTH-1:0] mdu_data_o,
  output logic                  mdu_pipeline_stall_o,
  output logic                  mdu_busy_o,
  output logic                  mdu_div_zero_o
);

  localparam int DW = DATA_WIDTH;
  localparam int W2 = 2 * DW;
  localparam int S  = MUL_STAGES;
  localparam int K  = DIV_BITS_PER_CYCLE;
  localparam int N  = DW / K;
  localparam int MS = (S > 0) ? S : 1;
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'((S > 0) ? S - 1 : 0);
  localparam logic [CW-1:0] DIV_LAST = CW'(N - 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_DIVU  = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;
  localparam logic [3:0] OP_MADD  = 4'd10;
  localparam logic [3:0] OP_MADDU = 4'd11;
  localparam logic [3:0] OP_MSUB  = 4'd12;
  localparam logic [3:0] OP_MSUBU = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE, ST_MUL, ST_DIV, ST_DFIX
  } state_e;

  typedef enum logic [1:0] {
    M_WR, M_ADD, M_SUB, M_GPR
  } mop_e;

  state_e state_q, state_d;
  mop_e   mop_q, mop_d, mop_op;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DW-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [DW-1:0] div_q, div_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d;
  logic dz_q, dz_d;
  logic [W2-1:0] prod_q [MS];
  logic [W2-1:0] prod_d [MS];

  logic sgn, is_mul, is_mac, is_div, hilo_op;
  logic a_neg, b_neg, stall, accept, busy;
  logic [DW-1:0] a_mag, b_mag, data;
  logic [W2-1:0] prod_now, prod_res, hilo;
  logic [DW-1:0] step_r, step_q;
  logic [DW:0]   step_t;

  function automatic logic [W2-1:0] mul_wb(
    input mop_e m, input logic [W2-1:0] acc, input logic [W2-1:0] p);
    case (m)
      M_ADD:   return acc + p;
      M_SUB:   return acc - p;
      default: return p;
    endcase
  endfunction

  always_comb begin
    sgn     = 1'b0;
    is_mul  = 1'b0;
    is_mac  = 1'b0;
    is_div  = 1'b0;
    hilo_op = 1'b1;
    mop_op  = M_WR;
    case (mdu_op_i)
      OP_MULT:  begin sgn = 1'b1; is_mac = 1'b1; end
      OP_MULTU: is_mac = 1'b1;
      OP_MUL:   begin sgn = 1'b1; is_mul = 1'b1; hilo_op = 1'b0; end
      OP_DIV:   begin sgn = 1'b1; is_div = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
      OP_MADD:  begin sgn = 1'b1; is_mac = 1'b1; mop_op = M_ADD; end
      OP_MADDU: begin is_mac = 1'b1; mop_op = M_ADD; end
      OP_MSUB:  begin sgn = 1'b1; is_mac = 1'b1; mop_op = M_SUB; end
      OP_MSUBU: begin is_mac = 1'b1; mop_op = M_SUB; end
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: hilo_op = 1'b1;
      default:  hilo_op = 1'b0;
    endcase
  end

  assign a_neg = sgn & mdu_a_i[DW-1];
  assign b_neg = sgn & mdu_b_i[DW-1];
  assign a_mag = a_neg ? -mdu_a_i : mdu_a_i;
  assign b_mag = b_neg ? -mdu_b_i : mdu_b_i;
  assign hilo  = {hi_q, lo_q};

  assign prod_now = $signed({{DW{a_neg}}, mdu_a_i})
                  * $signed({{DW{b_neg}}, mdu_b_i});
  assign prod_res = (S == 0) ? prod_now : prod_q[MS-1];

  // Free-running product pipe; only one op is ever in flight.
  always_comb begin
    prod_d[0] = prod_now;
    for (int i = 1; i < MS; i++) prod_d[i] = prod_q[i-1];
  end

  always_comb begin
    step_r = rem_q;
    step_q = quo_q;
    step_t = '0;
    for (int k = 0; k < K; k++) begin
      step_t = {step_r, step_q[DW-1]};
      step_q = {step_q[DW-2:0], 1'b0};
      if (step_t >= {1'b0, div_q}) begin
        step_t    = step_t - {1'b0, div_q};
        step_q[0] = 1'b1;
      end
      step_r = step_t[DW-1:0];
    end
  end

  assign busy = (state_q != ST_IDLE)
              & !(state_q == ST_MUL && mop_q == M_GPR);

  always_comb begin
    stall = 1'b0;
    if (mdu_valid_i) begin
      if (is_mul) begin
        if (S == 0) stall = (state_q != ST_IDLE);
        else stall = !(state_q == ST_MUL && mop_q == M_GPR
                       && cnt_q == MUL_LAST);
      end else if (hilo_op) begin
        stall = (state_q != ST_IDLE);
      end
    end
    accept = mdu_valid_i & !stall & !mdu_flush_i;
    data = '0;
    if (accept) begin
      if (mdu_op_i == OP_MFHI) data = hi_q;
      if (mdu_op_i == OP_MFLO) data = lo_q;
      if (is_mul) data = prod_res[DW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    mop_d   = mop_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (mdu_valid_i && !mdu_flush_i) begin
          if (is_mul) begin
            if (S == 0) {hi_d, lo_d} = prod_now;
            else begin
              state_d = ST_MUL;
              mop_d   = M_GPR;
              cnt_d   = '0;
            end
          end else if (is_mac) begin
            if (S == 0) {hi_d, lo_d} = mul_wb(mop_op, hilo, prod_now);
            else begin
              state_d = ST_MUL;
              mop_d   = mop_op;
              cnt_d   = '0;
            end
          end else if (is_div) begin
            cnt_d  = '0;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            div_d  = b_mag;
            // Divisor 0 skips straight to the fixup with final values.
            if (mdu_b_i == '0) begin
              state_d = ST_DFIX;
              dz_d    = 1'b1;
              rem_d   = mdu_a_i;
              quo_d   = '1;
            end else begin
              state_d = ST_DIV;
              dz_d    = 1'b0;
              rem_d   = '0;
              quo_d   = a_mag;
            end
          end else if (mdu_op_i == OP_MTHI) begin
            hi_d = mdu_a_i;
          end else if (mdu_op_i == OP_MTLO) begin
            lo_d = mdu_a_i;
          end
        end
      end
      ST_MUL: begin
        if (mop_q == M_GPR) begin
          if (!mdu_valid_i || mdu_flush_i || !is_mul) begin
            state_d = ST_IDLE;
          end else if (cnt_q == MUL_LAST) begin
            state_d      = ST_IDLE;
            {hi_d, lo_d} = prod_res;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q == MUL_LAST) begin
          state_d      = ST_IDLE;
          {hi_d, lo_d} = mul_wb(mop_q, hilo, prod_res);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DIV: begin
        rem_d = step_r;
        quo_d = step_q;
        if (cnt_q == DIV_LAST) state_d = ST_DFIX;
        else cnt_d = cnt_q + 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        hi_d = (rneg_q && !dz_q) ? -rem_q : rem_q;
        lo_d = (qneg_q && !dz_q) ? -quo_q : quo_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mop_q   <= M_WR;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      for (int i = 0; i < MS; i++) prod_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mop_q   <= mop_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      for (int i = 0; i < MS; i++) prod_q[i] <= prod_d[i];
    end
  end

  assign mdu_data_o           = rst_i ? '0 : data;
  assign mdu_pipeline_stall_o = !rst_i & stall;
  assign mdu_busy_o           = !rst_i & busy;
  assign mdu_div_zero_o       = !rst_i & (state_q == ST_DFIX) & dz_q;

endmodule
